// File: rtl/cmd_exec_sync.sv
// Command execution/synchronisation stage: request, latch, wait for TIME_START, emit blank/pulse burst.
// Optional ABORT input is enabled by defining CMD_EXEC_ABORT_EN.
module cmd_exec_sync #(
  parameter int unsigned REQ_TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [63:0] TIME,
  input  logic        DATA_WR,
  input  logic [47:0] FREQ,
  input  logic [47:0] FREQ_STEP,
  input  logic [31:0] FREQ_RATE,
  input  logic [63:0] TIME_START,
  input  logic [15:0] N_impulse,
  input  logic [1:0]  TYPE_impulse,
  input  logic [31:0] Interval_Ti,
  input  logic [31:0] Interval_Tp,
  input  logic [31:0] Tblank1,
  input  logic [31:0] Tblank2,
`ifdef CMD_EXEC_ABORT_EN
  input  logic        ABORT,
`endif
  output logic        REQ_COMM,
  output logic        IMP,
  output logic        BLANK,
  output logic [47:0] FREQ_OUT,
  output logic [31:0] FREQ_RATE_OUT,
  output logic        FREQ_WR,
  output logic        BUSY,
  output logic        ERR_LATE
);

  typedef enum logic [2:0] {
    S_REQ, S_WAIT_CMD, S_ARMED, S_BLANK1, S_PULSE, S_GAP, S_TAIL
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, to_q, to_d;
  logic [15:0] pcnt_q, pcnt_d, np_q, np_d;
  logic [63:0] ts_q, ts_d;
  logic        step_en_q, step_en_d;
  logic [47:0] acc_q, acc_d, step_q, step_d, fout_q, fout_d;
  logic [31:0] rate_q, rate_d, rout_q, rout_d;
  logic [31:0] ti_q, ti_d, tp_q, tp_d, tb1_q, tb1_d, tb2_q, tb2_d;
  logic        req_q, imp_q, blank_q, busy_q, err_q, err_d, fwr_q, fwr_d;
  logic        go_burst, go_pulse, go_tail;
  logic [31:0] ti_m1, gap_m1;

  assign ti_m1  = (ti_q == '0) ? '0 : ti_q - 32'd1;
  assign gap_m1 = (tp_q > ti_q) ? tp_q - ti_q - 32'd1 : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    to_d      = to_q;
    np_d      = np_q;
    ts_d      = ts_q;
    step_en_d = step_en_q;
    acc_d     = acc_q;
    step_d    = step_q;
    rate_d    = rate_q;
    ti_d      = ti_q;
    tp_d      = tp_q;
    tb1_d     = tb1_q;
    tb2_d     = tb2_q;
    fout_d    = fout_q;
    rout_d    = rout_q;
    err_d     = 1'b0;
    fwr_d     = 1'b0;
    go_burst  = 1'b0;
    go_pulse  = 1'b0;
    go_tail   = 1'b0;
    case (state_q)
      S_REQ: begin
        state_d = S_WAIT_CMD;
        to_d    = '0;
      end
      S_WAIT_CMD: begin
        if (DATA_WR) begin
          ts_d      = TIME_START;
          step_en_d = (TYPE_impulse == 2'd2);
          np_d      = (TYPE_impulse == 2'd0) ? 16'd1 : N_impulse;
          acc_d     = FREQ;
          step_d    = FREQ_STEP;
          rate_d    = FREQ_RATE;
          ti_d      = Interval_Ti;
          tp_d      = Interval_Tp;
          tb1_d     = Tblank1;
          tb2_d     = Tblank2;
          if (TIME_START < TIME) begin
            err_d   = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_ARMED;
          end
        end else if (to_q == REQ_TIMEOUT - 1) begin
          state_d = S_REQ;
        end else begin
          to_d = to_q + 32'd1;
        end
      end
      S_ARMED: begin
        if (TIME >= ts_q) begin
          if (tb1_q != '0) begin
            state_d = S_BLANK1;
            cnt_d   = tb1_q - 32'd1;
          end else begin
            go_burst = 1'b1;
          end
        end
      end
      S_BLANK1: begin
        if (cnt_q == '0) go_burst = 1'b1;
        else             cnt_d = cnt_q - 32'd1;
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          if (pcnt_q == '0) begin
            go_tail = 1'b1;
          end else begin
            state_d = S_GAP;
            cnt_d   = gap_m1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          go_pulse = 1'b1;
          pcnt_d   = pcnt_q - 16'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_TAIL: begin
        if (cnt_q == '0) state_d = S_REQ;
        else             cnt_d = cnt_q - 32'd1;
      end
      default: state_d = S_REQ;
    endcase

    // Shared entry actions: burst start resolves to first pulse or straight to the tail.
    if (go_burst) begin
      if (np_q == '0) begin
        go_tail = 1'b1;
      end else begin
        go_pulse = 1'b1;
        pcnt_d   = np_q - 16'd1;
      end
    end
    if (go_pulse) begin
      state_d = S_PULSE;
      cnt_d   = ti_m1;
      fwr_d   = 1'b1;
      fout_d  = acc_q;
      rout_d  = rate_q;
      if (step_en_q) acc_d = acc_q + step_q;
    end
    if (go_tail) begin
      if (tb2_q != '0) begin
        state_d = S_TAIL;
        cnt_d   = tb2_q - 32'd1;
      end else begin
        state_d = S_REQ;
      end
    end

`ifdef CMD_EXEC_ABORT_EN
    if (ABORT && (state_q == S_ARMED || state_q == S_BLANK1 || state_q == S_PULSE ||
                  state_q == S_GAP || state_q == S_TAIL)) begin
      state_d = S_REQ;
      fwr_d   = 1'b0;
      fout_d  = fout_q;
      rout_d  = rout_q;
    end
`endif
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      to_q      <= '0;
      np_q      <= '0;
      ts_q      <= '0;
      step_en_q <= 1'b0;
      acc_q     <= '0;
      step_q    <= '0;
      rate_q    <= '0;
      ti_q      <= '0;
      tp_q      <= '0;
      tb1_q     <= '0;
      tb2_q     <= '0;
      fout_q    <= '0;
      rout_q    <= '0;
      req_q     <= 1'b0;
      imp_q     <= 1'b0;
      blank_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      fwr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      to_q      <= to_d;
      np_q      <= np_d;
      ts_q      <= ts_d;
      step_en_q <= step_en_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      rate_q    <= rate_d;
      ti_q      <= ti_d;
      tp_q      <= tp_d;
      tb1_q     <= tb1_d;
      tb2_q     <= tb2_d;
      fout_q    <= fout_d;
      rout_q    <= rout_d;
      req_q     <= (state_q == S_REQ);
      imp_q     <= (state_d == S_PULSE);
      blank_q   <= (state_d == S_BLANK1) || (state_d == S_TAIL);
      busy_q    <= (state_d != S_REQ) && (state_d != S_WAIT_CMD);
      err_q     <= err_d;
      fwr_q     <= fwr_d;
    end
  end

  assign REQ_COMM      = req_q;
  assign IMP           = imp_q;
  assign BLANK         = blank_q;
  assign BUSY          = busy_q;
  assign ERR_LATE      = err_q;
  assign FREQ_WR       = fwr_q;
  assign FREQ_OUT      = fout_q;
  assign FREQ_RATE_OUT = rout_q;

endmodule

// File: tb/tb_cmd_exec_sync.sv
// Randomised bench for cmd_exec_sync; expected waveforms derived from per-command timing arithmetic.
// Define CMD_EXEC_ABORT_EN to also exercise the ABORT input.
module tb_cmd_exec_sync;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [63:0] TIME;
  logic        DATA_WR;
  logic [47:0] FREQ, FREQ_STEP;
  logic [31:0] FREQ_RATE;
  logic [63:0] TIME_START;
  logic [15:0] N_impulse;
  logic [1:0]  TYPE_impulse;
  logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
`ifdef CMD_EXEC_ABORT_EN
  logic        ABORT;
`endif
  logic        REQ_COMM, IMP, BLANK, FREQ_WR, BUSY, ERR_LATE;
  logic [47:0] FREQ_OUT;
  logic [31:0] FREQ_RATE_OUT;

  cmd_exec_sync #(.REQ_TIMEOUT(1024)) dut (
    .CLK(CLK), .rst_n(rst_n), .TIME(TIME), .DATA_WR(DATA_WR),
    .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE),
    .TIME_START(TIME_START), .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse),
    .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
    .Tblank1(Tblank1), .Tblank2(Tblank2),
`ifdef CMD_EXEC_ABORT_EN
    .ABORT(ABORT),
`endif
    .REQ_COMM(REQ_COMM), .IMP(IMP), .BLANK(BLANK), .FREQ_OUT(FREQ_OUT),
    .FREQ_RATE_OUT(FREQ_RATE_OUT), .FREQ_WR(FREQ_WR), .BUSY(BUSY), .ERR_LATE(ERR_LATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          d;
    bit          late;
    int          delta;
    logic [1:0]  typ;
    logic [15:0] n;
    logic [47:0] f, st;
    logic [31:0] rate, ti, tp, tb1, tb2;
    bit          extra, abrt, rst;
  } cmd_t;

  int          cyc;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
  endtask

  function automatic logic [5:0] outs();
    return {REQ_COMM, ERR_LATE, BUSY, BLANK, IMP, FREQ_WR};
  endfunction

  // One cycle = negedge to negedge; inputs set here are consumed at the following posedge.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    TIME = base + 64'(cyc);
  endtask

  function automatic cmd_t mk(input int d, input bit late, input int delta, input logic [1:0] typ,
                              input logic [15:0] n, input logic [47:0] f, input logic [47:0] st,
                              input logic [31:0] ti, input logic [31:0] tp, input logic [31:0] tb1,
                              input logic [31:0] tb2, input bit extra, input bit abrt, input bit rst);
    cmd_t c;
    c.d = d; c.late = late; c.delta = delta; c.typ = typ; c.n = n; c.f = f; c.st = st;
    c.rate = $urandom; c.ti = ti; c.tp = tp; c.tb1 = tb1; c.tb2 = tb2;
    c.extra = extra; c.abrt = abrt; c.rst = rst;
    return c;
  endfunction

  // Entered in a cycle where REQ_COMM was just seen (block is in WAIT_CMD).
  task automatic run_cmd(input cmd_t c);
    longint w, c0, s0, e, fin, reqc, a, rst_at, wi, wg, per, np, rel, k;
    logic [5:0]  ex;
    logic [47:0] fexp;
    bit          fw;
    repeat (c.d) begin
      tick();
      chk("idle", 64'(outs()), 64'd0);
    end
    w = cyc;
    DATA_WR = 1'b1;
    FREQ = c.f; FREQ_STEP = c.st; FREQ_RATE = c.rate;
    TIME_START = c.late ? TIME - 64'(c.delta) : TIME + 64'(c.delta);
    N_impulse = c.n; TYPE_impulse = c.typ;
    Interval_Ti = c.ti; Interval_Tp = c.tp; Tblank1 = c.tb1; Tblank2 = c.tb2;

    wi  = (c.ti == 0) ? 1 : longint'(c.ti);
    wg  = (c.tp > c.ti) ? longint'(c.tp) - longint'(c.ti) : 1;
    per = wi + wg;
    np  = (c.typ == 2'd0) ? 1 : longint'(c.n);
    c0  = (c.delta > 1) ? w + c.delta : w + 1;
    s0  = c0 + 1 + longint'(c.tb1);
    e   = (np == 0) ? s0 : s0 + (np - 1) * per + wi;
    fin = e + longint'(c.tb2);
    reqc = c.late ? w + 2 : fin + 1;
    a = -1;
    if (c.abrt && !c.late && np >= 2) begin
      a = s0 + per + 1;
      reqc = a + 2;
    end
    rst_at = c.rst ? s0 + 1 : -1;

    for (longint n = w + 1; n <= reqc; n++) begin
      tick();
      DATA_WR = 1'b0;
      if (c.extra && !c.late && n == w + 3 && w + 3 < fin) begin
        DATA_WR = 1'b1;
        FREQ = 48'($urandom); TIME_START = '0; N_impulse = 16'($urandom);
        Interval_Ti = 32'd1; Interval_Tp = 32'd1; Tblank2 = 32'd7;
      end
`ifdef CMD_EXEC_ABORT_EN
      ABORT = (n == a);
`endif
      fw = 1'b0;
      k = 0;
      if (c.late) begin
        ex = {n == w + 2, n == w + 1, 4'b0};
      end else if (a >= 0 && n > a) begin
        ex = {n == a + 2, 5'b0};
      end else begin
        rel = n - s0;
        k   = (rel >= 0) ? rel / per : 0;
        fw  = (rel >= 0) && (k < np) && (rel % per == 0);
        ex  = {n == reqc, 1'b0, n < fin,
               (n > c0 && n < s0) || (n >= e && n < fin),
               (rel >= 0) && (k < np) && (rel % per < wi), fw};
      end
      chk("outs", 64'(outs()), 64'(ex));
      if (fw) begin
        fexp = (c.typ == 2'd2) ? c.f + 48'(k) * c.st : c.f;
        chk("freq_out", 64'(FREQ_OUT), 64'(fexp));
        chk("rate_out", 64'(FREQ_RATE_OUT), 64'(c.rate));
      end
      if (n == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {10'd0, outs(), FREQ_OUT}, 64'd0);
        return;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    DATA_WR = 1'b0; FREQ = '0; FREQ_STEP = '0; FREQ_RATE = '0; TIME_START = '0;
    N_impulse = '0; TYPE_impulse = '0; Interval_Ti = '0; Interval_Tp = '0;
    Tblank1 = '0; Tblank2 = '0;
`ifdef CMD_EXEC_ABORT_EN
    ABORT = 1'b0;
`endif
    base = {32'h0000_0100, $urandom};
    cyc = -4;
    TIME = base - 64'd4;
    repeat (3) begin
      tick();
      chk("reset_outs", {10'd0, outs(), FREQ_OUT}, 64'd0);
      chk("reset_rate", 64'(FREQ_RATE_OUT), 64'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    chk("req_first", 64'(outs()), 64'h20);
    for (int i = 2; i <= 1025; i++) begin
      tick();
      chk("wait_timeout", 64'(outs()), 64'd0);
    end
    tick();
    chk("req_rerequest", 64'(outs()), 64'h20);

    run_cmd(mk(1, 0, 100, 2'd2, 16'd3, 48'd1000, 48'd10, 32'd4, 32'd10, 32'd2, 32'd3, 0, 0, 0));
    run_cmd(mk(0, 1, 1,   2'd1, 16'd2, 48'd5,    48'd1,  32'd2, 32'd4,  32'd1, 32'd1, 0, 0, 0));
    run_cmd(mk(2, 0, 5,   2'd0, 16'd5, 48'd77,   48'd3,  32'd3, 32'd6,  32'd0, 32'd0, 0, 0, 0));
    run_cmd(mk(0, 0, 0,   2'd1, 16'd0, 48'd9,    48'd1,  32'd3, 32'd6,  32'd2, 32'd3, 0, 0, 0));
    run_cmd(mk(1, 0, 3,   2'd1, 16'd2, 48'd42,   48'd0,  32'd5, 32'd2,  32'd1, 32'd1, 1, 0, 0));
    run_cmd(mk(0, 0, 2,   2'd2, 16'd4, 48'hFFFF_FFFF_FFF0, 48'h10, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0));
    run_cmd(mk(0, 0, 0,   2'd3, 16'd2, 48'd11,   48'd5,  32'd2, 32'd3,  32'd0, 32'd0, 0, 0, 0));

    for (int i = 0; i < 40; i++) begin
      bit late;
      late = ($urandom_range(0, 5) == 0);
      run_cmd(mk($urandom_range(0, 3), late,
                 late ? $urandom_range(1, 50) : $urandom_range(0, 30),
                 2'($urandom_range(0, 3)), 16'($urandom_range(0, 4)),
                 48'({$urandom, $urandom}), 48'({$urandom, $urandom}),
                 $urandom_range(0, 6), $urandom_range(0, 12),
                 $urandom_range(0, 4), $urandom_range(0, 4),
                 1'($urandom_range(0, 1)), 0, 0));
    end

`ifdef CMD_EXEC_ABORT_EN
    run_cmd(mk(0, 0, 4, 2'd1, 16'd3, 48'd500, 48'd0, 32'd4, 32'd10, 32'd2, 32'd3, 0, 1, 0));
`endif
    run_cmd(mk(0, 0, 3, 2'd1, 16'd3, 48'd123, 48'd0, 32'd6, 32'd10, 32'd1, 32'd2, 0, 0, 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
